// File: rtl/serial_pattern_rx_if.sv
// serial_pattern_rx_if -- bundles the serial line, the compare value and the
// consumer handshake of serial_pattern_rx.
// The optional overrun flag is present only when SERIAL_RX_OVERRUN_EN is defined.
interface serial_pattern_rx_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 serial_in;
  logic                 bit_stb;
  logic [BUS_WIDTH-1:0] pattern;
  logic                 ack;
  logic [BUS_WIDTH-1:0] rx_data;
  logic                 ready_in;
  logic                 pattern_match;
  logic                 busy;
`ifdef SERIAL_RX_OVERRUN_EN
  logic                 overrun;
`endif

  // Line driver / consumer side.
  modport master (
    output serial_in, bit_stb, pattern, ack,
`ifdef SERIAL_RX_OVERRUN_EN
    input  overrun,
`endif
    input  rx_data, ready_in, pattern_match, busy
  );

  // Receiver side.
  modport slave (
    input  serial_in, bit_stb, pattern, ack,
`ifdef SERIAL_RX_OVERRUN_EN
    output overrun,
`endif
    output rx_data, ready_in, pattern_match, busy
  );
endinterface

// File: rtl/serial_pattern_rx.sv
// serial_pattern_rx -- strobed serial receiver (start bit 0, BUS_WIDTH data
// bits LSB-first, stop bit 1) with a ready/ack handshake and a pattern compare.
// Optional feature macro: SERIAL_RX_OVERRUN_EN adds the overrun flag.
module serial_pattern_rx #(
  parameter int BUS_WIDTH      = 8,
  parameter bit MATCH_ON_FRAME = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  serial_pattern_rx_if.slave  bus
);

  localparam int CNT_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BUS_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [BUS_WIDTH-1:0] shift_reg;
  logic [BUS_WIDTH-1:0] rx_data_q;
  logic                 ready_q;

  // Decoded one-cycle actions from the FSM.
  logic clr_cnt;
  logic shift_en;
  logic frame_good;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and action decode; nothing moves without a bit strobe.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    clr_cnt    = 1'b0;
    shift_en   = 1'b0;
    frame_good = 1'b0;
    case (state)
      IDLE: begin
        if (bus.bit_stb && !bus.serial_in) begin
          clr_cnt   = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bus.bit_stb) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bus.bit_stb) begin
          // A low stop bit is a framing error: drop the word silently.
          frame_good = bus.serial_in;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);

  // Bit counter: cleared by the start bit, never wraps past the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (clr_cnt) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      if (bit_cnt == LAST_BIT) bit_cnt <= '0;
      else                     bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // LSB-first shift: the first data bit ends up in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           shift_reg <= '0;
    else if (shift_en) shift_reg <= {bus.serial_in, shift_reg[BUS_WIDTH-1:1]};
  end

  // Output word: loaded only by a good stop bit; a newer word overwrites.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rx_data_q <= '0;
    else if (frame_good) rx_data_q <= shift_reg;
  end

  // Ready flag: completion takes priority over a same-edge ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ready_q <= 1'b0;
    else if (frame_good) ready_q <= 1'b1;
    else if (bus.ack)    ready_q <= 1'b0;
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.ready_in = ready_q;

  generate
    if (MATCH_ON_FRAME) begin : g_match_frame
      logic match_q;

      // Compare captured alongside rx_data; held until the next good frame.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)             match_q <= 1'b0;
        else if (frame_good) match_q <= (shift_reg == bus.pattern);
      end

      assign bus.pattern_match = match_q;
    end else begin : g_match_cont
      assign bus.pattern_match = (rx_data_q == bus.pattern);
    end
  endgenerate

`ifdef SERIAL_RX_OVERRUN_EN
  logic overrun_q;

  // Overrun: a good word landed on top of an unacknowledged one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        overrun_q <= 1'b0;
    else if (frame_good && ready_q) overrun_q <= 1'b1;
    else if (bus.ack)               overrun_q <= 1'b0;
  end

  assign bus.overrun = overrun_q;
`endif

endmodule

// File: tb/tb_serial_pattern_rx.sv
// tb_serial_pattern_rx -- directed bench for serial_pattern_rx (BUS_WIDTH=8,
// MATCH_ON_FRAME=1). Overrun checks are compiled in with SERIAL_RX_OVERRUN_EN.
module tb_serial_pattern_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serial_pattern_rx_if #(.BUS_WIDTH(8)) bus ();

  serial_pattern_rx #(
    .BUS_WIDTH      (8),
    .MATCH_ON_FRAME (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // One strobed bit; returns 1 ns after the sampling edge.
  task automatic strobe(input logic b, input logic ack_with);
    bus.bit_stb   = 1'b1;
    bus.serial_in = b;
    bus.ack       = ack_with;
    @(posedge clk);
    #1;
    bus.bit_stb   = 1'b0;
    bus.serial_in = 1'b1;
    bus.ack       = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start bit, 8 data bits LSB-first, stop bit; optional random gaps and
  // an ack driven on the stop strobe.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int max_gap, input logic ack_at_stop);
    strobe(1'b0, 1'b0);
    idle_cycles(int'($urandom_range(0, max_gap)));
    for (int i = 0; i < 8; i++) begin
      strobe(data[i], 1'b0);
      idle_cycles(int'($urandom_range(0, max_gap)));
    end
    strobe(stop_bit, ack_at_stop);
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    @(posedge clk);
    #1;
    bus.ack = 1'b0;
  endtask

  initial begin
    bus.serial_in = 1'b1;
    bus.bit_stb   = 1'b0;
    bus.ack       = 1'b0;
    bus.pattern   = 8'hA5;

    // Reset state.
    rst = 1'b1;
    idle_cycles(2);
    check_word("rst_rx_data", bus.rx_data, 8'h00);
    check_bit ("rst_ready", bus.ready_in, 1'b0);
    check_bit ("rst_match", bus.pattern_match, 1'b0);
    check_bit ("rst_busy", bus.busy, 1'b0);
`ifdef SERIAL_RX_OVERRUN_EN
    check_bit ("rst_overrun", bus.overrun, 1'b0);
`endif
    rst = 1'b0;
    idle_cycles(2);

    // Good frame 0xA5 matching the pattern.
    strobe(1'b0, 1'b0);
    check_bit ("a5_busy_after_start", bus.busy, 1'b1);
    for (int i = 0; i < 8; i++) strobe(((8'hA5 >> i) & 8'h01) != 0, 1'b0);
    check_bit ("a5_busy_in_stop", bus.busy, 1'b1);
    check_bit ("a5_ready_before_stop", bus.ready_in, 1'b0);
    strobe(1'b1, 1'b0);
    check_word("a5_rx_data", bus.rx_data, 8'hA5);
    check_bit ("a5_ready", bus.ready_in, 1'b1);
    check_bit ("a5_match", bus.pattern_match, 1'b1);
    check_bit ("a5_busy_done", bus.busy, 1'b0);
    pulse_ack();
    check_bit ("a5_ready_acked", bus.ready_in, 1'b0);

    // 0x3C against pattern 0xA5, then ack.
    send_frame(8'h3C, 1'b1, 0, 1'b0);
    check_word("3c_rx_data", bus.rx_data, 8'h3C);
    check_bit ("3c_ready", bus.ready_in, 1'b1);
    check_bit ("3c_match", bus.pattern_match, 1'b0);
    pulse_ack();
    check_bit ("3c_ready_acked", bus.ready_in, 1'b0);
    check_word("3c_rx_held", bus.rx_data, 8'h3C);

    // Framing error on 0x11: nothing changes even though it would match.
    bus.pattern = 8'h11;
    send_frame(8'h11, 1'b0, 0, 1'b0);
    check_word("ferr_rx_data", bus.rx_data, 8'h3C);
    check_bit ("ferr_ready", bus.ready_in, 1'b0);
    check_bit ("ferr_match", bus.pattern_match, 1'b0);
    check_bit ("ferr_busy", bus.busy, 1'b0);

    // Ack with nothing pending has no effect; idle strobes of 1 do not start.
    pulse_ack();
    strobe(1'b1, 1'b0);
    check_bit ("idle_ack_ready", bus.ready_in, 1'b0);
    check_word("idle_ack_rx", bus.rx_data, 8'h3C);
    check_bit ("idle_one_busy", bus.busy, 1'b0);

    // 0x77 left unacknowledged, then 0x22 completes with ack on the same edge.
    bus.pattern = 8'h22;
    send_frame(8'h77, 1'b1, 0, 1'b0);
    check_bit ("77_ready", bus.ready_in, 1'b1);
    check_bit ("77_match", bus.pattern_match, 1'b0);
`ifdef SERIAL_RX_OVERRUN_EN
    check_bit ("77_overrun", bus.overrun, 1'b0);
`endif
    send_frame(8'h22, 1'b1, 0, 1'b1);
    check_bit ("22_ready_wins", bus.ready_in, 1'b1);
    check_word("22_rx_data", bus.rx_data, 8'h22);
    check_bit ("22_match", bus.pattern_match, 1'b1);
`ifdef SERIAL_RX_OVERRUN_EN
    check_bit ("22_overrun", bus.overrun, 1'b1);
`endif
    pulse_ack();
    check_bit ("22_ready_acked", bus.ready_in, 1'b0);
`ifdef SERIAL_RX_OVERRUN_EN
    check_bit ("22_overrun_acked", bus.overrun, 1'b0);
`endif

    // Reset after 4 data bits, asynchronously between edges.
    bus.pattern = 8'hA5;
    strobe(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_word("mid_rst_rx_data", bus.rx_data, 8'h00);
    check_bit ("mid_rst_ready", bus.ready_in, 1'b0);
    check_bit ("mid_rst_match", bus.pattern_match, 1'b0);
    check_bit ("mid_rst_busy", bus.busy, 1'b0);
    idle_cycles(1);
    rst = 1'b0;
    idle_cycles(1);
    // Remaining bits of the abandoned frame are 1s: must not restart.
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
    check_bit ("post_rst_idle", bus.busy, 1'b0);
    send_frame(8'hFF, 1'b1, 0, 1'b0);
    check_word("ff_rx_data", bus.rx_data, 8'hFF);
    check_bit ("ff_ready", bus.ready_in, 1'b1);
    check_bit ("ff_match", bus.pattern_match, 1'b0);
    pulse_ack();

    // 0x5A with random 0-5 cycle strobe gaps.
    bus.pattern = 8'h5A;
    send_frame(8'h5A, 1'b1, 5, 1'b0);
    check_word("gap_rx_data", bus.rx_data, 8'h5A);
    check_bit ("gap_ready", bus.ready_in, 1'b1);
    check_bit ("gap_match", bus.pattern_match, 1'b1);
    check_bit ("gap_busy", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
